// File: rtl/fifo_uart_tx_pkg.sv
// fifo_uart_tx_pkg: FSM state encoding and default bit time shared by the FIFO-draining UART transmitter
package fifo_uart_tx_pkg;
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETTLE = 3'd1,
      START  = 3'd2,
      DATA   = 3'd3,
      PARITY = 3'd4,
      STOP   = 3'd5
   } state_t;
   localparam int DEF_CLKS_PER_BIT = 16;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-time counter, bit_tick high on the terminal count CLKS_PER_BIT-1
//   clk      in  clock
//   rst_n    in  asynchronous active-low reset
//   clr      in  restart the count at 0 on the next cycle
//   bit_tick out high on the last cycle of each bit time
module uart_baud_tick
   import fifo_uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic bit_tick
);
   localparam int W = $clog2(CLKS_PER_BIT);
   localparam logic [W-1:0] TERM = W'(CLKS_PER_BIT - 1);
   logic [W-1:0] cnt_q;
   assign bit_tick = cnt_q == TERM;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else cnt_q <= clr || bit_tick ? '0 : cnt_q + 1'b1;
   end
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from an FWFT FIFO and sends each as a UART frame (optional even parity, 1 or 2 stop bits)
//   clk        in  clock
//   rst_n      in  asynchronous active-low reset
//   ena        in  allows new frames to start
//   fifo_data  in  FIFO read data, valid the cycle after fifo_empty falls
//   fifo_empty in  FIFO empty flag
//   fifo_rd    out one-cycle pop strobe
//   tx         out registered serial line, idle high
//   busy       out high from the pop cycle through the last stop-bit cycle
module fifo_uart_tx
   import fifo_uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int PARITY_EN    = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] fifo_data,
   input  logic       fifo_empty,
   output logic       fifo_rd,
   output logic       tx,
   output logic       busy
);
   localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
   state_t     state_q, state_d;
   logic [7:0] shift_q;
   logic [2:0] idx_q;
   logic       par_q, tx_d, bit_tick, clr;
   // restarting the counter while popping gives the start bit a full bit time
   assign clr = state_q == SETTLE;
   uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .bit_tick (bit_tick)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else state_q <= state_d;
   end
   always_comb begin
      state_d = IDLE;
      case (state_q)
         IDLE:    state_d = ena && !fifo_empty ? SETTLE : IDLE;
         SETTLE:  state_d = fifo_empty ? IDLE : START;
         START:   state_d = bit_tick ? DATA : START;
         DATA:    state_d = !bit_tick || idx_q != 3'd7 ? DATA : PARITY_EN != 0 ? PARITY : STOP;
         PARITY:  state_d = bit_tick ? STOP : PARITY;
         STOP:    state_d = bit_tick && idx_q == LAST_STOP ? IDLE : STOP;
         default: state_d = IDLE;
      endcase
   end
   // tx_d is the line level for the coming cycle, so tx changes together with the state
   always_comb begin
      fifo_rd = state_q == SETTLE && !fifo_empty;
      busy    = fifo_rd || state_q inside {START, DATA, PARITY, STOP};
      tx_d    = fifo_rd ? 1'b0 :
                !(state_q inside {START, DATA, PARITY}) ? 1'b1 :
                !bit_tick ? tx :
                state_q == START ? shift_q[0] :
                state_q == PARITY ? 1'b1 :
                idx_q != 3'd7 ? shift_q[1] :
                PARITY_EN != 0 ? par_q ^ shift_q[0] : 1'b1;
   end
   // idx_q wraps to 0 leaving DATA and is then reused to count stop bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= '0;
         idx_q   <= '0;
         par_q   <= 1'b0;
         tx      <= 1'b1;
      end else begin
         tx <= tx_d;
         if (fifo_rd) begin
            shift_q <= fifo_data;
            idx_q   <= '0;
            par_q   <= 1'b0;
         end else if (bit_tick && state_q == DATA) begin
            shift_q <= {1'b0, shift_q[7:1]};
            idx_q   <= idx_q + 1'b1;
            par_q   <= par_q ^ shift_q[0];
         end else if (bit_tick && state_q == STOP) begin
            idx_q   <= idx_q + 1'b1;
         end
      end
   end
endmodule
